spart_fifo: RTL and testbench

- Parametrised successor to the team's SPART; the driver talks to it over the same iocs/iorw/ioaddr/databus bus.
- Adds TX and RX FIFOs, configurable character width, and runtime-selectable parity.
- Adds sticky overrun, framing and parity error flags, plus glitch-rejecting start-bit detection.
- Serial side connects directly to the RS232 txd/rxd pins.

---
 rtl/spart_pkg.sv | 43 ++++
 rtl/sync_fifo.sv | 56 +++++
 rtl/spart_fifo.sv | 270 +++++++++++++++++++++++++++
 tb/tb_spart_fifo.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared constants and helpers for the FIFO-buffered SPART.
package spart_pkg;

   localparam logic [1:0] ADDR_DATA = 2'b00;
   localparam logic [1:0] ADDR_STAT = 2'b01;
   localparam logic [1:0] ADDR_DIVL = 2'b10;
   localparam logic [1:0] ADDR_DIVH = 2'b11;

   typedef enum logic [1:0] {
      PAR_NONE     = 2'b00,
      PAR_EVEN     = 2'b01,
      PAR_ODD      = 2'b10,
      PAR_NONE_ALT = 2'b11
   } par_e;

   localparam int ST_RDA    = 0;
   localparam int ST_TBR    = 1;
   localparam int ST_TXIDLE = 2;
   localparam int ST_OVR    = 3;
   localparam int ST_FERR   = 4;
   localparam int ST_PERR   = 5;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } ser_state_e;

   function automatic logic par_en(input par_e m);
      return (m == PAR_EVEN) || (m == PAR_ODD);
   endfunction

   // Data is zero-extended to 8 bits by callers; extra zeros leave parity unchanged.
   function automatic logic par_calc(input logic [7:0] d, input par_e m);
      return (m == PAR_ODD) ? ~^d : ^d;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with flush; push is accepted on a full FIFO
// when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_rdata,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_pop;
   logic             w_push;

   assign w_pop   = i_pop && (r_count != '0);
   assign w_push  = i_push && ((r_count != FULL_CNT) || w_pop);
   assign o_rdata = r_mem[r_rptr];
   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

   always_ff @(posedge clk) begin
      if (!rst || i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_wdata;
   end

endmodule

// File: rtl/spart_fifo.sv
// FIFO-buffered SPART: bus register file, baud generator, TX/RX serial FSMs.
//
// state    | meaning
// S_IDLE   | TX: waiting for a tick with data queued; RX: waiting for a falling edge
// S_START  | start bit (RX re-checks the line at mid-bit to reject glitches)
// S_DATA   | data bits, LSB first, 16 ticks each
// S_PARITY | parity bit, only when parity is enabled for this frame
// S_STOP   | stop bit; RX samples it at mid-bit and pushes the character
module spart_fifo
   import spart_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int FIFO_DEPTH  = 8,
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = 650
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   output logic       rda,
   output logic       tbr,
   output logic       txd,
   input  logic       rxd
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE - 1);
   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

   logic                 w_rd, w_wr, w_stat_rd, w_flush, w_div_wr;
   logic                 w_tx_push, w_tx_pop, w_rx_pop, w_rx_ovf;
   logic                 w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   logic [CW-1:0]        w_tx_count, w_rx_count;
   logic [DATA_BITS-1:0] w_tx_head, w_rx_head;
   logic [DIV_W-1:0]     w_div_next;
   logic [7:0]           w_status, w_rdata;
   logic                 w_tick, w_tx_idle;

   logic [DIV_W-1:0]     r_div, r_baud_cnt;
   par_e                 r_par_mode;
   logic                 r_ovr, r_ferr, r_perr;

   ser_state_e           r_tx_state;
   logic [3:0]           r_tx_tick;
   logic [2:0]           r_tx_bit;
   logic [DATA_BITS-1:0] r_tx_data;
   par_e                 r_tx_par;
   logic                 r_txd;

   logic                 r_rxd_s1, r_rxd_s2, r_rxd_s3;
   ser_state_e           r_rx_state;
   logic [3:0]           r_rx_tick;
   logic [2:0]           r_rx_bit;
   logic [DATA_BITS-1:0] r_rx_data;
   par_e                 r_rx_par;
   logic                 r_rx_pbit, r_rx_push, r_rx_ferr_evt, r_rx_perr_evt;

   assign w_rd      = iocs && iorw;
   assign w_wr      = iocs && !iorw;
   assign w_stat_rd = w_rd && (ioaddr == ADDR_STAT);
   assign w_flush   = w_wr && (ioaddr == ADDR_STAT) && databus[7];
   assign w_div_wr  = w_wr && ioaddr[1];
   assign w_tx_push = w_wr && (ioaddr == ADDR_DATA);
   assign w_rx_pop  = w_rd && (ioaddr == ADDR_DATA) && !w_rx_empty;
   assign w_tx_pop  = w_tick && (r_tx_state == S_IDLE) && !w_tx_empty;
   assign w_rx_ovf  = r_rx_push && w_rx_full && !w_rx_pop && !w_flush;

   assign w_div_next = (ioaddr == ADDR_DIVL) ? {r_div[DIV_W-1:8], databus}
                                             : {databus[DIV_W-9:0], r_div[7:0]};

   assign rda       = (w_rx_count != '0);
   assign tbr       = !w_tx_full;
   assign txd       = r_txd;
   assign w_tx_idle = (r_tx_state == S_IDLE) && (w_tx_count == '0);
   assign w_status  = {2'b00, r_perr, r_ferr, r_ovr, w_tx_idle, tbr, rda};
   assign w_rdata   = (ioaddr == ADDR_STAT) ? w_status
                    : (w_rx_empty ? 8'h00 : 8'(w_rx_head));
   assign databus   = (w_rd && !ioaddr[1]) ? w_rdata : 8'bz;

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_flush),
      .i_push  (w_tx_push),
      .i_wdata (databus[DATA_BITS-1:0]),
      .i_pop   (w_tx_pop),
      .o_rdata (w_tx_head),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty),
      .o_count (w_tx_count)
   );

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_flush),
      .i_push  (r_rx_push),
      .i_wdata (r_rx_data),
      .i_pop   (w_rx_pop),
      .o_rdata (w_rx_head),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty),
      .o_count (w_rx_count)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_div      <= DIV_W'(DEFAULT_DIV);
         r_par_mode <= PAR_NONE;
      end else if (w_wr) begin
         if (ioaddr == ADDR_STAT) r_par_mode <= par_e'(databus[1:0]);
         if (w_div_wr)            r_div      <= w_div_next;
      end
   end

   // A divisor write restarts the count so the new rate applies at once.
   always_ff @(posedge clk) begin
      if (!rst)                   r_baud_cnt <= DIV_W'(DEFAULT_DIV);
      else if (w_div_wr)          r_baud_cnt <= w_div_next;
      else if (r_baud_cnt == '0)  r_baud_cnt <= r_div;
      else                        r_baud_cnt <= r_baud_cnt - 1'b1;
   end

   assign w_tick = (r_baud_cnt == '0);

   // Sticky flags: a new event wins over the clear-on-read.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ovr  <= 1'b0;
         r_ferr <= 1'b0;
         r_perr <= 1'b0;
      end else begin
         if (w_rx_ovf)           r_ovr  <= 1'b1;
         else if (w_stat_rd)     r_ovr  <= 1'b0;
         if (r_rx_ferr_evt)      r_ferr <= 1'b1;
         else if (w_stat_rd)     r_ferr <= 1'b0;
         if (r_rx_perr_evt)      r_perr <= 1'b1;
         else if (w_stat_rd)     r_perr <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_tx_state <= S_IDLE;
         r_tx_tick  <= '0;
         r_tx_bit   <= '0;
         r_tx_data  <= '0;
         r_tx_par   <= PAR_NONE;
         r_txd      <= 1'b1;
      end else if (w_tick) begin
         r_tx_tick <= r_tx_tick + 4'd1;
         case (r_tx_state)
            S_IDLE: begin
               r_tx_tick <= '0;
               if (!w_tx_empty) begin
                  r_tx_state <= S_START;
                  r_tx_bit   <= '0;
                  r_tx_data  <= w_tx_head;
                  r_tx_par   <= r_par_mode;
                  r_txd      <= 1'b0;
               end
            end
            S_START: if (r_tx_tick == LAST_TICK) begin
               r_tx_state <= S_DATA;
               r_txd      <= r_tx_data[0];
            end
            S_DATA: if (r_tx_tick == LAST_TICK) begin
               if (r_tx_bit == LAST_BIT) begin
                  if (par_en(r_tx_par)) begin
                     r_tx_state <= S_PARITY;
                     r_txd      <= par_calc(8'(r_tx_data), r_tx_par);
                  end else begin
                     r_tx_state <= S_STOP;
                     r_txd      <= 1'b1;
                  end
               end else begin
                  r_tx_bit <= r_tx_bit + 3'd1;
                  r_txd    <= r_tx_data[r_tx_bit + 3'd1];
               end
            end
            S_PARITY: if (r_tx_tick == LAST_TICK) begin
               r_tx_state <= S_STOP;
               r_txd      <= 1'b1;
            end
            S_STOP: if (r_tx_tick == LAST_TICK) r_tx_state <= S_IDLE;
            default: begin
               r_tx_state <= S_IDLE;
               r_txd      <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rxd_s1 <= 1'b1;
         r_rxd_s2 <= 1'b1;
         r_rxd_s3 <= 1'b1;
      end else begin
         r_rxd_s1 <= rxd;
         r_rxd_s2 <= r_rxd_s1;
         r_rxd_s3 <= r_rxd_s2;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rx_state    <= S_IDLE;
         r_rx_tick     <= '0;
         r_rx_bit      <= '0;
         r_rx_data     <= '0;
         r_rx_par      <= PAR_NONE;
         r_rx_pbit     <= 1'b0;
         r_rx_push     <= 1'b0;
         r_rx_ferr_evt <= 1'b0;
         r_rx_perr_evt <= 1'b0;
      end else begin
         r_rx_push     <= 1'b0;
         r_rx_ferr_evt <= 1'b0;
         r_rx_perr_evt <= 1'b0;
         case (r_rx_state)
            S_IDLE: if (r_rxd_s3 && !r_rxd_s2) begin
               r_rx_state <= S_START;
               r_rx_tick  <= '0;
               r_rx_bit   <= '0;
               r_rx_par   <= r_par_mode;
            end
            S_START: if (w_tick) begin
               r_rx_tick <= r_rx_tick + 4'd1;
               if (r_rx_tick == MID_TICK) begin
                  r_rx_tick  <= '0;
                  r_rx_state <= r_rxd_s2 ? S_IDLE : S_DATA;
               end
            end
            S_DATA: if (w_tick) begin
               r_rx_tick <= r_rx_tick + 4'd1;
               if (r_rx_tick == LAST_TICK) begin
                  r_rx_data[r_rx_bit] <= r_rxd_s2;
                  r_rx_bit            <= r_rx_bit + 3'd1;
                  if (r_rx_bit == LAST_BIT)
                     r_rx_state <= par_en(r_rx_par) ? S_PARITY : S_STOP;
               end
            end
            S_PARITY: if (w_tick) begin
               r_rx_tick <= r_rx_tick + 4'd1;
               if (r_rx_tick == LAST_TICK) begin
                  r_rx_pbit  <= r_rxd_s2;
                  r_rx_state <= S_STOP;
               end
            end
            S_STOP: if (w_tick) begin
               r_rx_tick <= r_rx_tick + 4'd1;
               if (r_rx_tick == LAST_TICK) begin
                  r_rx_push     <= 1'b1;
                  r_rx_ferr_evt <= !r_rxd_s2;
                  r_rx_perr_evt <= par_en(r_rx_par) &&
                                   (r_rx_pbit != par_calc(8'(r_rx_data), r_rx_par));
                  r_rx_state    <= S_IDLE;
               end
            end
            default: r_rx_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spart_fifo.sv
// Bench for spart_fifo: bus tasks, serial frame injection, and a queue of
// expected RX bytes checked on every data-register read.
`timescale 1ns/1ps
module tb_spart_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       iocs = 1'b0;
   logic       iorw = 1'b0;
   logic [1:0] ioaddr = 2'b00;
   wire  [7:0] databus;
   logic       rda, tbr, txd, rxd;

   logic       r_drv = 1'b0;
   logic [7:0] r_wdata = 8'h00;
   logic       r_loop = 1'b0;
   logic       r_rxd_drv = 1'b1;

   assign databus = r_drv ? r_wdata : 8'bz;
   assign rxd     = r_loop ? txd : r_rxd_drv;

   always #5 clk = ~clk;

   spart_fifo #(.DATA_BITS(8), .FIFO_DEPTH(8), .DIV_W(16), .DEFAULT_DIV(650)) dut (
      .clk     (clk),
      .rst     (rst),
      .iocs    (iocs),
      .iorw    (iorw),
      .ioaddr  (ioaddr),
      .databus (databus),
      .rda     (rda),
      .tbr     (tbr),
      .txd     (txd),
      .rxd     (rxd)
   );

   typedef struct {
      logic [7:0] data;
      logic [1:0] par;
      logic       flip;
      logic       stopb;
      logic [7:0] exp_stat;
   } rx_vec_t;

   rx_vec_t    vt [8];
   logic [7:0] exp_q [$];
   int         total = 0;
   int         bad = 0;
   int         div_now = 650;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      iocs = 1'b1; iorw = 1'b0; ioaddr = a; r_wdata = d; r_drv = 1'b1;
      @(negedge clk);
      iocs = 1'b0; r_drv = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      iocs = 1'b1; iorw = 1'b1; ioaddr = a;
      #1 d = databus;
      @(negedge clk);
      iocs = 1'b0; iorw = 1'b0;
   endtask

   task automatic set_div(input logic [15:0] v);
      bus_wr(2'b10, v[7:0]);
      bus_wr(2'b11, v[15:8]);
      div_now = int'(v);
   endtask

   task automatic rd_data_check(input string name);
      logic [7:0] d;
      logic [7:0] e;
      bus_rd(2'b00, d);
      e = (exp_q.size() == 0) ? 8'h00 : exp_q.pop_front();
      check(name, d, e);
   endtask

   task automatic stat_check(input string name, input logic [7:0] e);
      logic [7:0] s;
      bus_rd(2'b01, s);
      check(name, s, e);
   endtask

   // Drive one serial frame on rxd and predict what the RX FIFO keeps.
   task automatic inject(input logic [7:0] d, input logic [1:0] par, input logic flip,
                         input logic stopb);
      int   bt;
      logic pb;
      bt = 16 * (div_now + 1);
      if (exp_q.size() < 8) exp_q.push_back(d);
      @(negedge clk);
      r_rxd_drv = 1'b0;
      repeat (bt) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         r_rxd_drv = d[i];
         repeat (bt) @(negedge clk);
      end
      if (par == 2'b01 || par == 2'b10) begin
         pb = ((par == 2'b10) ? ~^d : ^d) ^ flip;
         r_rxd_drv = pb;
         repeat (bt) @(negedge clk);
      end
      r_rxd_drv = stopb;
      repeat (bt) @(negedge clk);
      r_rxd_drv = 1'b1;
      repeat (bt) @(negedge clk);
   endtask

   initial begin
      logic [7:0] tx_byte;
      int         n;
      int         txm;

      vt[0] = '{8'h55, 2'b00, 1'b0, 1'b1, 8'h06};
      vt[1] = '{8'hA3, 2'b01, 1'b0, 1'b1, 8'h06};
      vt[2] = '{8'h3C, 2'b10, 1'b0, 1'b1, 8'h06};
      vt[3] = '{8'h81, 2'b00, 1'b0, 1'b0, 8'h16};
      vt[4] = '{8'h5C, 2'b10, 1'b1, 1'b1, 8'h26};
      vt[5] = '{8'hFF, 2'b01, 1'b0, 1'b0, 8'h16};
      vt[6] = '{8'h00, 2'b10, 1'b1, 1'b0, 8'h36};
      vt[7] = '{8'hC9, 2'b01, 1'b1, 1'b1, 8'h26};

      // reset defaults
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_txd", txd, 1'b1);
      check("reset_rda", rda, 1'b0);
      check("reset_tbr", tbr, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      stat_check("reset_status", 8'h06);

      // loopback single character, 64 clocks per bit
      set_div(16'd3);
      bus_wr(2'b01, 8'h00);
      r_loop = 1'b1;
      tx_byte = 8'h55;
      exp_q.push_back(tx_byte);
      bus_wr(2'b00, tx_byte);
      n = 0;
      while (txd && n < 200) begin
         @(posedge clk); #1; n++;
      end
      check("lb_start_seen", txd, 1'b0);
      n = 0;
      while (!txd && n < 200) begin
         @(posedge clk); #1; n++;
      end
      check("lb_start_len", n, 64);
      for (int b = 0; b < 8; b++) begin
         repeat (32) @(posedge clk);
         #1;
         check($sformatf("lb_bit%0d", b), txd, tx_byte[b]);
         repeat (32) @(posedge clk);
         #1;
      end
      repeat (32) @(posedge clk);
      #1;
      check("lb_stop", txd, 1'b1);
      n = 0;
      while (!rda && n < 1200) begin
         @(posedge clk); #1; n++;
      end
      check("lb_rda_rise", rda, 1'b1);
      rd_data_check("lb_data");
      check("lb_rda_fall", rda, 1'b0);

      // TX FIFO fill with the baud counter stalled
      set_div(16'hFFFF);
      txm = 0;
      for (int i = 0; i < 9; i++) begin
         if (txm < 8) begin
            exp_q.push_back(8'(i));
            txm++;
         end
         bus_wr(2'b00, 8'(i));
         check($sformatf("txfill_tbr%0d", i), tbr, (txm < 8) ? 1'b1 : 1'b0);
      end
      r_loop = 1'b1;
      set_div(16'd0);
      repeat (2500) @(posedge clk);
      r_loop = 1'b0;
      for (int i = 0; i < 8; i++) rd_data_check($sformatf("txfill_rx%0d", i));
      stat_check("txfill_status", 8'h06);

      // table of single RX frames: data, parity, errors
      for (int i = 0; i < 8; i++) begin
         bus_wr(2'b01, {6'b0, vt[i].par});
         inject(vt[i].data, vt[i].par, vt[i].flip, vt[i].stopb);
         rd_data_check($sformatf("vec%0d_data", i));
         stat_check($sformatf("vec%0d_status", i), vt[i].exp_stat);
      end

      // overrun, then framing and parity errors accumulate
      bus_wr(2'b01, 8'h00);
      for (int i = 0; i < 9; i++) inject(8'h10 + 8'(i), 2'b00, 1'b0, 1'b1);
      check("ovr_rda", rda, 1'b1);
      for (int i = 0; i < 8; i++) rd_data_check($sformatf("ovr_data%0d", i));
      inject(8'h42, 2'b00, 1'b0, 1'b0);
      bus_wr(2'b01, 8'h02);
      inject(8'h5C, 2'b10, 1'b1, 1'b1);
      rd_data_check("ferr_data");
      rd_data_check("perr_data");
      stat_check("sticky_all", 8'h3E);
      stat_check("sticky_clear", 8'h06);

      // glitch rejection: 3-tick low pulse
      bus_wr(2'b01, 8'h00);
      set_div(16'd3);
      @(negedge clk);
      r_rxd_drv = 1'b0;
      repeat (12) @(negedge clk);
      r_rxd_drv = 1'b1;
      repeat (400) @(posedge clk);
      #1;
      check("glitch_rda", rda, 1'b0);
      stat_check("glitch_status", 8'h06);

      // reset in the middle of a TX frame
      set_div(16'd0);
      bus_wr(2'b00, 8'h00);
      bus_wr(2'b00, 8'h11);
      bus_wr(2'b00, 8'h22);
      n = 0;
      while (txd && n < 100) begin
         @(posedge clk); #1; n++;
      end
      repeat (20) @(posedge clk);
      #1;
      check("midtx_low", txd, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("midtx_rst_txd", txd, 1'b1);
      check("midtx_rst_tbr", tbr, 1'b1);
      check("midtx_rst_rda", rda, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      stat_check("midtx_status", 8'h06);
      repeat (50) @(posedge clk);
      #1;
      check("midtx_txd_idle", txd, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
